// File: rtl/distance_avg_bcd_pkg.sv
// Purpose: shared constants, FSM encoding and the double-dabble step helper
//          for the distance averaging / BCD conversion block.
// Contents: data/BCD widths, converter iteration count, 3-bit FSM state codes,
//           dabble_t working register layout, dabble_step() function.
package distance_avg_bcd_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned BCD_DIGITS  = 4;
    localparam int unsigned BCD_W       = 4 * BCD_DIGITS;
    localparam int unsigned CONV_CYCLES = 16;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned STATE_W     = 3;

    localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] ST_ACCUM      = 3'd1;
    localparam logic [STATE_W-1:0] ST_CONV_START = 3'd2;
    localparam logic [STATE_W-1:0] ST_CONV_WAIT  = 3'd3;
    localparam logic [STATE_W-1:0] ST_OUTPUT     = 3'd4;

    // Double-dabble working register: BCD accumulator above the binary shifter.
    typedef struct packed {
        logic [BCD_W-1:0]  bcd;
        logic [DATA_W-1:0] bin;
    } dabble_t;

    // One iteration: add 3 to every digit >= 5, then shift the pair left by one.
    function automatic dabble_t dabble_step(input dabble_t cur);
        dabble_t adj;
        adj = cur;
        for (int d = 0; d < int'(BCD_DIGITS); d++) begin
            if (adj.bcd[4*d +: 4] >= 4'd5) begin
                adj.bcd[4*d +: 4] = adj.bcd[4*d +: 4] + 4'd3;
            end
        end
        return dabble_t'({adj.bcd[BCD_W-2:0], adj.bin, 1'b0});
    endfunction

endpackage

// File: rtl/distance_avg_bcd_bin2bcd_seq.sv
// Purpose: sequential double-dabble binary-to-BCD converter, one shift/add-3
//          iteration per clock, 16 iterations total.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset
//   start  in   one-cycle request; bin is sampled in this cycle
//   bin    in   16-bit binary value
//   busy   out  conversion in progress
//   done   out  one-cycle pulse, high 16 cycles after the start cycle
//   bcd    out  4-digit BCD result, valid from done until the next start
module bin2bcd_seq
    import distance_avg_bcd_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);

    dabble_t          r_work;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    dabble_t w_first;
    dabble_t w_next;

    // The first iteration is folded into the start cycle so done lands 16 cycles later.
    assign w_first = dabble_step(dabble_t'({{BCD_W{1'b0}}, bin}));
    assign w_next  = dabble_step(r_work);

    // Iteration counter and working register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_work <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_work <= w_first;
                r_cnt  <= CNT_W'(CONV_CYCLES - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_work <= w_next;
                r_cnt  <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_work.bcd;

endmodule

// File: rtl/distance_avg_bcd.sv
// Purpose: takes finished HC-SR04 distance samples, range-checks them, keeps a
//          2^AVG_LOG2-deep moving average and presents it in binary and BCD.
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   distance      in   measured distance in cm, valid while echo_done is high
//   echo_done     in   measurement complete; rising edge = new sample
//   avg_distance  out  moving-average distance in cm
//   bcd           out  avg_distance as 4-digit BCD
//   out_valid     out  one-cycle pulse on update or rejected sample
//   out_of_range  out  last sample failed the range check
//   busy          out  FSM not idle
//   overrun       out  sticky: sample edge arrived while busy
module distance_avg_bcd
    import distance_avg_bcd_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned MIN_CM   = 2,
    parameter int unsigned MAX_CM   = 400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] distance,
    input  logic              echo_done,
    output logic [DATA_W-1:0] avg_distance,
    output logic [BCD_W-1:0]  bcd,
    output logic              out_valid,
    output logic              out_of_range,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned DEPTH = 1 << AVG_LOG2;
    localparam int unsigned SUM_W = DATA_W + AVG_LOG2;

    logic [STATE_W-1:0]  r_state;
    logic                r_echo_d;
    logic [DATA_W-1:0]   r_sample;
    logic [DATA_W-1:0]   r_buf [DEPTH];
    logic [SUM_W-1:0]    r_sum;
    logic [AVG_LOG2-1:0] r_wr_ptr;
    logic                r_primed;
    logic [DATA_W-1:0]   r_avg;
    logic [DATA_W-1:0]   r_avg_out;
    logic [BCD_W-1:0]    r_bcd_out;
    logic                r_out_valid;
    logic                r_oor;
    logic                r_busy;
    logic                r_overrun;

    logic [STATE_W-1:0]  w_state_next;
    logic [DATA_W-1:0]   w_sample_next;
    logic [DATA_W-1:0]   w_buf_next [DEPTH];
    logic [SUM_W-1:0]    w_sum_next;
    logic [AVG_LOG2-1:0] w_wr_ptr_next;
    logic                w_primed_next;
    logic [DATA_W-1:0]   w_avg_next;
    logic [DATA_W-1:0]   w_avg_out_next;
    logic [BCD_W-1:0]    w_bcd_out_next;
    logic                w_out_valid_next;
    logic                w_oor_next;
    logic                w_overrun_next;
    logic                w_busy_next;

    logic                w_event;
    logic                w_in_range;
    logic [DATA_W-1:0]   w_conv_bin;
    logic                w_conv_start_c;
    logic                w_conv_busy;
    logic                w_conv_done;
    logic [BCD_W-1:0]    w_conv_bcd;

    assign w_event    = echo_done & ~r_echo_d;
    assign w_in_range = (distance >= DATA_W'(MIN_CM)) && (distance <= DATA_W'(MAX_CM));

    // Floor average; fed straight from the sum so the converter starts with the fresh value.
    assign w_conv_bin     = DATA_W'(r_sum >> AVG_LOG2);
    assign w_conv_start_c = (r_state == ST_CONV_START);

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (w_conv_start_c),
        .bin   (w_conv_bin),
        .busy  (w_conv_busy),
        .done  (w_conv_done),
        .bcd   (w_conv_bcd)
    );

    // Next-state and next-value logic for the FSM and datapath.
    always_comb begin
        w_state_next     = r_state;
        w_sample_next    = r_sample;
        w_buf_next       = r_buf;
        w_sum_next       = r_sum;
        w_wr_ptr_next    = r_wr_ptr;
        w_primed_next    = r_primed;
        w_avg_next       = r_avg;
        w_avg_out_next   = r_avg_out;
        w_bcd_out_next   = r_bcd_out;
        w_out_valid_next = 1'b0;
        w_oor_next       = r_oor;
        // Edges arriving outside IDLE are dropped and flagged.
        w_overrun_next   = r_overrun | (w_event & (r_state != ST_IDLE));

        case (r_state)
            ST_IDLE: begin
                if (w_event) begin
                    w_sample_next = distance;
                    if (w_in_range) begin
                        w_state_next = ST_ACCUM;
                    end else begin
                        w_oor_next       = 1'b1;
                        w_out_valid_next = 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                if (!r_primed) begin
                    // First sample fills the whole window so the average starts at that value.
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        w_buf_next[i] = r_sample;
                    end
                    w_sum_next    = SUM_W'(r_sample) << AVG_LOG2;
                    w_primed_next = 1'b1;
                end else begin
                    w_sum_next             = r_sum - SUM_W'(r_buf[r_wr_ptr]) + SUM_W'(r_sample);
                    w_buf_next[r_wr_ptr]   = r_sample;
                    w_wr_ptr_next          = r_wr_ptr + AVG_LOG2'(1);
                end
                w_state_next = ST_CONV_START;
            end
            ST_CONV_START: begin
                w_avg_next   = w_conv_bin;
                w_state_next = ST_CONV_WAIT;
            end
            ST_CONV_WAIT: begin
                if (w_conv_done && !w_conv_busy) begin
                    w_state_next = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                w_avg_out_next   = r_avg;
                w_bcd_out_next   = w_conv_bcd;
                w_oor_next       = 1'b0;
                w_out_valid_next = 1'b1;
                w_state_next     = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_busy_next = (w_state_next != ST_IDLE);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_echo_d    <= 1'b0;
            r_sample    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_buf[i] <= '0;
            end
            r_sum       <= '0;
            r_wr_ptr    <= '0;
            r_primed    <= 1'b0;
            r_avg       <= '0;
            r_avg_out   <= '0;
            r_bcd_out   <= '0;
            r_out_valid <= 1'b0;
            r_oor       <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_echo_d    <= echo_done;
            r_sample    <= w_sample_next;
            r_buf       <= w_buf_next;
            r_sum       <= w_sum_next;
            r_wr_ptr    <= w_wr_ptr_next;
            r_primed    <= w_primed_next;
            r_avg       <= w_avg_next;
            r_avg_out   <= w_avg_out_next;
            r_bcd_out   <= w_bcd_out_next;
            r_out_valid <= w_out_valid_next;
            r_oor       <= w_oor_next;
            r_busy      <= w_busy_next;
            r_overrun   <= w_overrun_next;
        end
    end

    assign avg_distance = r_avg_out;
    assign bcd          = r_bcd_out;
    assign out_valid    = r_out_valid;
    assign out_of_range = r_oor;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_distance_avg_bcd.sv
// Purpose: directed self-checking bench for distance_avg_bcd.
// Cycle k counts clock edges after the edge that sampled the echo_done rise;
// k = 1 is the cycle right after that edge.
module tb_distance_avg_bcd;

    logic        clk;
    logic        reset;
    logic [15:0] distance;
    logic        echo_done;
    logic [15:0] avg_distance;
    logic [15:0] bcd;
    logic        out_valid;
    logic        out_of_range;
    logic        busy;
    logic        overrun;

    int n_total;
    int n_pass;
    int k;
    int pulses;
    int last_k;

    distance_avg_bcd dut (
        .clk          (clk),
        .reset        (reset),
        .distance     (distance),
        .echo_done    (echo_done),
        .avg_distance (avg_distance),
        .bcd          (bcd),
        .out_valid    (out_valid),
        .out_of_range (out_of_range),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance n cycles, sampling 1 ns after each edge and logging out_valid pulses.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (out_valid === 1'b1) begin
                pulses++;
                last_k = k;
            end
        end
    endtask

    task automatic watch_start();
        k      = 0;
        pulses = 0;
        last_k = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(1);
    endtask

    // One echo_done pulse, then check latency, single pulse and final outputs.
    task automatic send(input logic [15:0] d, input int exp_lat, input logic [15:0] exp_avg,
                        input logic [15:0] exp_bcd, input logic exp_oor, input string tag);
        watch_start();
        distance  = d;
        echo_done = 1'b1;
        run(1);
        check({tag, "_busy_k1"}, 32'(busy), 32'(exp_lat > 1));
        echo_done = 1'b0;
        run(29);
        check({tag, "_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_latency"}, 32'(last_k), 32'(exp_lat));
        check({tag, "_avg"}, 32'(avg_distance), 32'(exp_avg));
        check({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
        check({tag, "_oor"}, 32'(out_of_range), 32'(exp_oor));
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        reset     = 1'b1;
        echo_done = 1'b0;
        distance  = 16'd0;
        watch_start();
        run(3);
        check("rst_avg", 32'(avg_distance), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_oor", 32'(out_of_range), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        run(2);

        // Priming sample and moving average: 100 -> 101 -> 103 -> 106.
        send(16'd100, 20, 16'd100, 16'h0100, 1'b0, "s100");
        send(16'd104, 20, 16'd101, 16'h0101, 1'b0, "s104");
        send(16'd108, 20, 16'd103, 16'h0103, 1'b0, "s108");
        send(16'd112, 20, 16'd106, 16'h0106, 1'b0, "s112");

        // Rejected samples hold the result; next good sample clears the flag.
        send(16'd1,   1, 16'd106, 16'h0106, 1'b1, "rej1");
        send(16'd450, 1, 16'd106, 16'h0106, 1'b1, "rej450");
        send(16'd112, 20, 16'd109, 16'h0109, 1'b0, "s112b");

        // echo_done held high for 50 cycles gives one update.
        watch_start();
        distance  = 16'd116;
        echo_done = 1'b1;
        run(50);
        echo_done = 1'b0;
        run(20);
        check("hold_pulses", 32'(pulses), 32'd1);
        check("hold_latency", 32'(last_k), 32'd20);
        check("hold_avg", 32'(avg_distance), 32'd112);
        check("hold_bcd", 32'(bcd), 32'h0112);
        check("hold_overrun", 32'(overrun), 32'd0);

        // Second edge sampled at T+5 is dropped and flagged.
        watch_start();
        distance  = 16'd120;
        echo_done = 1'b1;
        run(1);
        echo_done = 1'b0;
        run(4);
        distance  = 16'd300;
        echo_done = 1'b1;
        run(1);
        check("ovr_busy_t5", 32'(busy), 32'd1);
        echo_done = 1'b0;
        run(30);
        check("ovr_pulses", 32'(pulses), 32'd1);
        check("ovr_latency", 32'(last_k), 32'd20);
        check("ovr_avg", 32'(avg_distance), 32'd115);
        check("ovr_bcd", 32'(bcd), 32'h0115);
        check("ovr_flag", 32'(overrun), 32'd1);

        // Reset sampled at T+10 aborts the conversion.
        watch_start();
        distance  = 16'd124;
        echo_done = 1'b1;
        run(1);
        echo_done = 1'b0;
        run(9);
        reset = 1'b1;
        run(1);
        check("abort_avg", 32'(avg_distance), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_overrun", 32'(overrun), 32'd0);
        run(2);
        reset = 1'b0;
        run(25);
        check("abort_pulses", 32'(pulses), 32'd0);
        check("abort_oor", 32'(out_of_range), 32'd0);
        send(16'd250, 20, 16'd250, 16'h0250, 1'b0, "s250");

        // Range boundaries.
        do_reset();
        send(16'd2, 20, 16'd2, 16'h0002, 1'b0, "min2");
        do_reset();
        send(16'd400, 20, 16'd400, 16'h0400, 1'b0, "max400");
        send(16'd401, 1, 16'd400, 16'h0400, 1'b1, "rej401");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
